nth_root: RTL and testbench

Sequential integer N-th root extractor: the inverse of the registered power unit. It accepts an N*WIDTH-bit operand X and returns R = floor(X^(1/N)) as a WIDTH-bit result. It sits downstream of the multi-precision arithmetic datapath, so values produced by the power path can be checked or reduced back. It uses one WIDTH x (N*WIDTH) multiplier, iterated per trial bit, under a valid/ready handshake on both sides.

---
 rtl/nth_root.sv | 154 +++++++++++++++
 tb/tb_nth_root.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nth_root.sv
// nth_root: sequential integer N-th root, R = floor(X^(1/N)), one trial bit per N+1 cycles.
// Optional feature macro: NTH_ROOT_REM_EN adds the pbest register and the o_rem = X - R^N port.
module nth_root #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned N     = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [N*WIDTH-1:0] i_x,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_root
`ifdef NTH_ROOT_REM_EN
  ,
  output logic [N*WIDTH-1:0] o_rem
`endif
);

  localparam int unsigned XW = N * WIDTH;
  localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW = (N > 2) ? $clog2(N - 1) : 1;

  // Degree below 2 has no meaning for this datapath
  if (N < 2) begin : g_n_check
    $error("nth_root: N must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIAL,
    S_POW,
    S_CMP,
    S_DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [XW-1:0]   x_q;
  logic [XW-1:0]   p_q;
  logic [WIDTH-1:0] root_q;
  logic [KW-1:0]   k_q;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] cand;
  logic            take;
  logic            ld_c;
  logic            trial_c;
  logic            pow_c;
  logic            cmp_c;
`ifdef NTH_ROOT_REM_EN
  logic [XW-1:0]   pbest_q;
  logic [XW-1:0]   rem_q;
`endif

  assign cand   = root_q | (WIDTH'(1) << k_q);
  assign take   = (p_q <= x_q);
  assign o_root = root_q;
`ifdef NTH_ROOT_REM_EN
  assign o_rem  = rem_q;
`endif

  // State register; handshake flags track the state being entered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      o_ready <= (state_d == S_IDLE);
      o_valid <= (state_d == S_DONE);
    end
  end

  // Next-state: one TRIAL, N-1 POW, one CMP per bit, MSB first
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid) state_d = S_TRIAL;
      S_TRIAL: state_d = S_POW;
      S_POW:   if (cnt_q == '0) state_d = S_CMP;
      S_CMP:   state_d = (k_q == '0) ? S_DONE : S_TRIAL;
      S_DONE:  if (i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    ld_c    = 1'b0;
    trial_c = 1'b0;
    pow_c   = 1'b0;
    cmp_c   = 1'b0;
    case (state_q)
      S_IDLE:  ld_c    = i_valid;
      S_TRIAL: trial_c = 1'b1;
      S_POW:   pow_c   = 1'b1;
      S_CMP:   cmp_c   = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, power iteration and per-bit accept/reject
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q    <= '0;
      p_q    <= '0;
      root_q <= '0;
      k_q    <= '0;
      cnt_q  <= '0;
`ifdef NTH_ROOT_REM_EN
      pbest_q <= '0;
      rem_q   <= '0;
`endif
    end else begin
      if (ld_c) begin
        x_q    <= i_x;
        root_q <= '0;
        k_q    <= KW'(WIDTH - 1);
`ifdef NTH_ROOT_REM_EN
        pbest_q <= '0;
`endif
      end
      if (trial_c) begin
        p_q   <= XW'(cand);
        cnt_q <= CW'(N - 2);
      end
      if (pow_c) begin
        // cand < 2^WIDTH so cand^N fits in XW bits; truncation loses nothing
        p_q <= p_q * XW'(cand);
        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      end
      if (cmp_c) begin
        if (take) begin
          root_q <= cand;
`ifdef NTH_ROOT_REM_EN
          pbest_q <= p_q;
`endif
        end
        if (k_q != '0) begin
          k_q <= k_q - KW'(1);
        end
`ifdef NTH_ROOT_REM_EN
        else begin
          // Final bit: latch the remainder so it is held for the whole DONE phase
          rem_q <= x_q - (take ? p_q : pbest_q);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_nth_root.sv
// tb_nth_root: scoreboard bench for nth_root with WIDTH=8, N=3.
module tb_nth_root;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 3;
  localparam int unsigned XW    = N * WIDTH;
  localparam int unsigned LAT   = WIDTH * (N + 1);

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [XW-1:0]    i_x;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_root;
`ifdef NTH_ROOT_REM_EN
  logic [XW-1:0]    o_rem;
`endif

  typedef struct {
    logic [WIDTH-1:0] root;
    logic [XW-1:0]    rem;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  nth_root #(.WIDTH(WIDTH), .N(N)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_x     (i_x),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_root  (o_root)
`ifdef NTH_ROOT_REM_EN
    ,
    .o_rem   (o_rem)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: largest r with r^3 <= x, found by linear search
  function automatic exp_t model(input logic [XW-1:0] x);
    exp_t e;
    longint unsigned r = 0;
    while (r < 255 && (r + 1) * (r + 1) * (r + 1) <= longint'(x)) r++;
    e.root = WIDTH'(r);
    e.rem  = XW'(longint'(x) - r * r * r);
    return e;
  endfunction

  task automatic send(input logic [XW-1:0] x);
    int w = 0;
    while (!o_ready && w < 100) begin
      tick();
      w++;
    end
    check("send_ready", 64'(o_ready), 64'(1));
    i_valid = 1'b1;
    i_x     = x;
    sb.push_back(model(x));
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_result();
    int lat = 0;
    while (!o_valid && lat < int'(LAT) + 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(LAT));
    check("busy_ready", 64'(o_ready), 64'(0));
  endtask

  task automatic consume(input int hold);
    exp_t e;
    e.root = '0;
    e.rem  = '0;
    check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) e = sb.pop_front();
    i_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 64'(o_valid), 64'(1));
      check("hold_ready", 64'(o_ready), 64'(0));
      check("hold_root", 64'(o_root), 64'(e.root));
`ifdef NTH_ROOT_REM_EN
      check("hold_rem", 64'(o_rem), 64'(e.rem));
`endif
    end
    check("root", 64'(o_root), 64'(e.root));
`ifdef NTH_ROOT_REM_EN
    check("rem", 64'(o_rem), 64'(e.rem));
`endif
    i_ready = 1'b1;
    tick();
    check("valid_drop", 64'(o_valid), 64'(0));
    check("ready_rise", 64'(o_ready), 64'(1));
    i_ready = 1'b0;
  endtask

  initial begin
    logic [XW-1:0] vec [6];
    vec[0] = 24'd27;
    vec[1] = 24'd1000;
    vec[2] = 24'd999;
    vec[3] = 24'd0;
    vec[4] = 24'd16777215;
    vec[5] = 24'd16777216 - 24'd1 - 24'd195840;

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_x     = '0;
    tick();
    tick();
    i_rst = 1'b0;
    check("rst_ready", 64'(o_ready), 64'(1));
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_root", 64'(o_root), 64'(0));
`ifdef NTH_ROOT_REM_EN
    check("rst_rem", 64'(o_rem), 64'(0));
`endif

    // Exact cubes, non-exact values and both range ends
    foreach (vec[i]) begin
      send(vec[i]);
      wait_result();
      consume(0);
    end

    // Output backpressure on the all-ones operand
    send(24'hFFFFFF);
    wait_result();
    consume(10);

    // Random operands
    for (int i = 0; i < 4; i++) begin
      send(XW'($urandom_range(0, 32'h00FF_FFFF)));
      wait_result();
      consume(i);
    end

    // Busy protection: a second operand held valid during the computation
    send(24'd64);
    i_valid = 1'b1;
    i_x     = 24'd125;
    wait_result();
    consume(0);
    send(24'd125);
    wait_result();
    consume(0);

    // Mid-operation reset aborts the operand silently
    send(24'd200);
    repeat (10) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    void'(sb.pop_back());
    check("abort_ready", 64'(o_ready), 64'(1));
    check("abort_valid", 64'(o_valid), 64'(0));
    check("abort_root", 64'(o_root), 64'(0));
    send(24'd8);
    wait_result();
    consume(0);

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
